// File: rtl/quadrature_debouncer.sv
// Two-channel synchroniser and debouncer for raw quadrature encoder contacts.
// A level is accepted only after it has been stable for STABLE_CYCLES cycles.
module quadrature_debouncer #(
    parameter int   STABLE_CYCLES = 1024,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic edge_a,
    output logic edge_b
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [CW-1:0]          cnt_q  [2];
    logic [1:0]             out_q;
    logic [1:0]             edge_q;

    assign raw = {b_raw, a_raw};

    // Index 0 is channel A, index 1 is channel B; the channels never interact.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {SYNC_STAGES{RESET_LEVEL}};
                cnt_q[i]  <= '0;
            end
            out_q  <= {2{RESET_LEVEL}};
            edge_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_q[i][SYNC_STAGES-1] == out_q[i]) begin
                    cnt_q[i]  <= '0;
                    edge_q[i] <= 1'b0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    out_q[i]  <= sync_q[i][SYNC_STAGES-1];
                    cnt_q[i]  <= '0;
                    edge_q[i] <= 1'b1;
                end else begin
                    cnt_q[i]  <= cnt_q[i] + CW'(1);
                    edge_q[i] <= 1'b0;
                end
            end
        end
    end

    assign a      = out_q[0];
    assign b      = out_q[1];
    assign edge_a = edge_q[0];
    assign edge_b = edge_q[1];

endmodule

// File: tb/tb_quadrature_debouncer.sv
// Directed bench for quadrature_debouncer with STABLE_CYCLES=4 / SYNC_STAGES=2,
// plus a second instance with STABLE_CYCLES=1 sharing the same raw inputs.
module tb_quadrature_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, edge_a, edge_b;
    logic a1, b1, edge_a1, edge_b1;

    int checks = 0;
    int errors = 0;
    int na, nb, ta, tb, pos, neg;
    logic a_prev, b_prev;

    always #5 clk = ~clk;

    quadrature_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
        .a(a), .b(b), .edge_a(edge_a), .edge_b(edge_b)
    );

    quadrature_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
        .a(a1), .b(b1), .edge_a(edge_a1), .edge_b(edge_b1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int phase(input logic [1:0] v);
        case (v)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic clr();
        na = 0; nb = 0; ta = 0; tb = 0; pos = 0; neg = 0;
        a_prev = a; b_prev = b;
    endtask

    // One clock: pass a rising edge, then sample at the following falling edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (edge_a) na++;
            if (edge_b) nb++;
            if (a != a_prev) ta++;
            if (b != b_prev) tb++;
            if ({a, b} != {a_prev, b_prev}) begin
                if (phase({a, b}) == (phase({a_prev, b_prev}) + 1) % 4) pos++;
                else if (phase({a_prev, b_prev}) == (phase({a, b}) + 1) % 4) neg++;
            end
            a_prev = a; b_prev = b;
        end
    endtask

    task automatic run_seq(input logic [1:0] s1, input logic [1:0] s2,
                           input logic [1:0] s3, input logic [1:0] s4, input string tag);
        logic [1:0] seq [5];
        seq[0] = 2'b11; seq[1] = s1; seq[2] = s2; seq[3] = s3; seq[4] = s4;
        clr();
        for (int i = 1; i < 5; i++) begin
            {a_raw, b_raw} = seq[i];
            tick(5);
            chk({tag, "_hold"}, int'({a, b}), int'(seq[i-1]));
            tick(1);
            chk({tag, "_new"}, int'({a, b}), int'(seq[i]));
            tick(4);
        end
    endtask

    initial begin
        @(negedge clk);
        // 1. Reset with raw low, then idle high
        rst = 1'b1; a_raw = 1'b0; b_raw = 1'b0;
        tick(2);
        chk("rst_ab", int'({a, b}), 3);
        chk("rst_edges", int'({edge_a, edge_b}), 0);
        rst = 1'b0; a_raw = 1'b1; b_raw = 1'b1;
        clr();
        tick(50);
        chk("idle_ab", int'({a, b}), 3);
        chk("idle_strobes", na + nb, 0);

        // 2. Latency, with the STABLE_CYCLES=1 instance checked alongside
        a_raw = 1'b0;
        tick(2);
        chk("s1_hold", int'(a1), 1);
        tick(1);
        chk("s1_fall", int'({a1, edge_a1}), 2'b01);
        tick(2);
        chk("lat_hold", int'(a), 1);
        tick(1);
        chk("lat_fall", int'({a, edge_a}), 2'b01);
        chk("lat_b_quiet", int'({b, edge_b}), 2'b10);
        tick(1);
        chk("lat_pulse_end", int'(edge_a), 0);
        tick(10);
        a_raw = 1'b1;
        tick(5);
        chk("lat_rise_hold", int'(a), 0);
        tick(1);
        chk("lat_rise", int'({a, edge_a}), 2'b11);
        tick(1);
        chk("lat_rise_end", int'(edge_a), 0);
        tick(10);

        // 3. Glitch of 3 cycles rejected, 4 cycles accepted
        clr();
        a_raw = 1'b0; tick(3); a_raw = 1'b1; tick(12);
        chk("glitch3_a", int'(a), 1);
        chk("glitch3_edges", na, 0);
        clr();
        a_raw = 1'b0; tick(4); a_raw = 1'b1;
        tick(2);
        chk("pulse4_fall", int'({a, edge_a}), 2'b01);
        tick(3);
        chk("pulse4_low", int'(a), 0);
        tick(1);
        chk("pulse4_rise", int'({a, edge_a}), 2'b11);
        tick(10);
        chk("pulse4_edges", na, 2);

        // 4. Bounce then settle low
        clr();
        for (int i = 0; i < 10; i++) begin
            a_raw = ~a_raw;
            tick(2);
        end
        a_raw = 1'b0;
        tick(5);
        chk("bounce_hold", int'(a), 1);
        tick(1);
        chk("bounce_fall", int'({a, edge_a}), 2'b01);
        tick(20);
        chk("bounce_edges", na, 1);
        chk("bounce_trans", ta, 1);
        a_raw = 1'b1;
        tick(12);

        // 5. Quadrature sequences, forward then mirrored
        run_seq(2'b01, 2'b00, 2'b10, 2'b11, "fwd");
        chk("fwd_trans", ta * 10 + tb, 22);
        chk("fwd_dir", pos * 10 + neg, 40);
        run_seq(2'b10, 2'b00, 2'b01, 2'b11, "rev");
        chk("rev_trans", ta * 10 + tb, 22);
        chk("rev_dir", pos * 10 + neg, 4);

        // 6. Simultaneous change, then a reset landing mid-count
        a_raw = 1'b0; b_raw = 1'b0;
        tick(5);
        chk("sim_hold", int'({a, b}), 3);
        tick(1);
        chk("sim_fall", int'({a, b, edge_a, edge_b}), 4'b0011);
        a_raw = 1'b1; b_raw = 1'b1;
        tick(12);
        a_raw = 1'b0; b_raw = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_ab", int'({a, b, edge_a, edge_b}), 4'b1100);
        rst = 1'b0;
        // Reset reloaded the synchronisers, so the low level must resync and recount.
        tick(5);
        chk("recount_hold", int'({a, b}), 3);
        tick(1);
        chk("recount_fall", int'({a, b, edge_a, edge_b}), 4'b0011);
        tick(1);
        chk("recount_end", int'({edge_a, edge_b}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
